mcdf_formater: RTL and testbench
================================

Name: mcdf_formater

Overview:
Formatter end of the arbiter-to-formatter link in the multi-channel data formatter. It requests a channel grant, latches the granted channel ID and packet length, and accepts exactly one packet of words through the val/ack handshake. It buffers the packet, then sends it downstream as a framed burst (start/send/end) after a req/grant exchange. Within the datapath it sits between the arbiter and the downstream packet consumer.

Parameters:
DW, 32, data word width
MAX_LEN, 32, maximum packet length in words; sets buffer depth
LW, 6, width of fmt_length_o; must hold MAX_LEN

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
a2f_val_i  in  1  arbiter data valid for the granted channel
a2f_id_i  in  2  granted channel ID; 2'b11 means no channel granted
a2f_data_i  in  DW  data word from the granted channel
a2f_pkglen_sel_i  in  3  packet length select for the granted channel
f2a_id_req_o  out  1  request to the arbiter to select a channel
f2a_ack_o  out  1  word-accept acknowledge to the arbiter
fmt_grant_i  in  1  downstream grant
fmt_req_o  out  1  downstream send request
fmt_chid_o  out  2  channel ID of the packet being sent
fmt_length_o  out  LW  packet length in words
fmt_send_o  out  1  fmt_data_o valid this cycle
fmt_data_o  out  DW  packet word
fmt_start_o  out  1  first word of the packet
fmt_end_o  out  1  last word of the packet

Behaviour:
- Reset is asynchronous and active-low on rstn_i; the clock is clk_i.
- Reset values: all outputs 0; state IDLE; buffer pointers 0.
- Length decode of a2f_pkglen_sel_i: 0 gives 4 words, 1 gives 8, 2 gives 16, and any other value gives 32.
- FSM states and transitions:
  - IDLE: moves to ID_REQ on the next cycle, unconditionally.
  - ID_REQ: lasts exactly one cycle. f2a_id_req_o = 1 combinationally in this state only. The arbiter latches its selection on this clock edge.
  - CHK: samples a2f_id_i and a2f_pkglen_sel_i.
    - If a2f_id_i == 2'b11, go to IDLE and retry; there is a 3-cycle retry period.
    - Otherwise, latch chid and len (decoded), clear wcnt, and go to COLLECT.
  - COLLECT: f2a_ack_o = a2f_val_i && (wcnt < len), combinationally.
    - A word is accepted when a2f_val_i && f2a_ack_o. It is written to buffer[wcnt], and wcnt increments.
    - When the len-th word is accepted, go to REQ. f2a_ack_o is never high for more than len words.
    - a2f_val_i low stalls indefinitely; there is no timeout.
  - REQ: fmt_req_o = 1 (registered), fmt_chid_o = chid, fmt_length_o = len.
    - When fmt_grant_i is sampled high, go to SEND. fmt_req_o drops in the first SEND cycle.
    - A grant that is already high on REQ entry is accepted on the first REQ cycle.
  - SEND: fmt_send_o = 1 for exactly len consecutive cycles, with fmt_data_o = buffer[rcnt] for rcnt = 0..len-1.
    - fmt_start_o is high with rcnt == 0; fmt_end_o is high with rcnt == len-1. Both are asserted simultaneously with fmt_send_o.
    - After the last word, go to IDLE.
- Registered outputs: fmt_* are registered. Latency from grant sampled to first data is 1 cycle.
- fmt_chid_o and fmt_length_o hold their value from REQ entry through the last SEND cycle, and are 0 otherwise.
- fmt_data_o is 0 when fmt_send_o is low.
- Output ordering: words are output in acceptance order; no reordering.
- f2a_ack_o and f2a_id_req_o are never high in the same cycle.
- Reset mid-operation: the partially collected packet is discarded and no output burst occurs. The arbiter selection is re-requested after reset.
- Width rules: wcnt and rcnt are LW bits and never exceed len. The buffer is MAX_LEN x DW and is not cleared on reset; its contents are don't-care until written.

Decomposition:
- Package mcdf_fmt_pkg holds:
  - the state enum (IDLE, ID_REQ, CHK, COLLECT, REQ, SEND);
  - the ID_NONE = 2'b11 constant;
  - the length-select encodings;
  - a function decode_len(sel) returning an LW-bit value.
- Sub-module fmt_pkt_buf: a MAX_LEN x DW single-write, single-read register array. It has a write enable/address/data port and a registered read port addressed by rcnt. The read is prefetched so that data aligns with fmt_send_o.

Test Plan:
- Reset: with rstn_i held low, all outputs are 0. After release, f2a_id_req_o pulses high for 1 cycle on the 2nd cycle.
- Channel 1 with pkglen_sel = 0 and words 0x11..0x14 on continuous valid: f2a_ack_o is high for exactly 4 accepts. fmt_req_o rises with fmt_chid_o = 1 and fmt_length_o = 4. Grant is delayed 5 cycles. The bench then sees 4 send cycles with data 0x11..0x14, start on the first word and end on the last.
- a2f_id_i = 2'b11 at CHK: no ack, no fmt_req_o, and f2a_id_req_o re-pulses every 3 cycles until the ID becomes valid.
- Channel 2 with pkglen_sel = 7 (decodes to 32 words) and a2f_val_i toggling every other cycle: exactly 32 words are accepted and fmt_length_o = 32. Data matches in order, and f2a_ack_o stays 0 after the 32nd word.
- fmt_grant_i held high continuously across two back-to-back packets (chid 0, then 1): each burst is correctly framed and the second burst carries fmt_chid_o = 1.
- rstn_i asserted after 3 of 8 words are collected: outputs are immediately 0 and no burst follows. After release the next packet is sent normally.

Source files
------------

// File: rtl/mcdf_fmt_pkg.sv
// Shared types and constants for the MCDF formatter: FSM states, the "no grant"
// channel ID and the packet-length select decoding.
package mcdf_fmt_pkg;

    localparam int FMT_LW = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        CHK     = 3'd2,
        COLLECT = 3'd3,
        REQ     = 3'd4,
        SEND    = 3'd5
    } fmt_state_e;

    localparam logic [1:0] ID_NONE = 2'b11;

    localparam logic [2:0] LEN_SEL_4  = 3'd0;
    localparam logic [2:0] LEN_SEL_8  = 3'd1;
    localparam logic [2:0] LEN_SEL_16 = 3'd2;

    // Every encoding above LEN_SEL_16 selects the maximum packet of 32 words.
    function automatic logic [FMT_LW-1:0] decode_len(input logic [2:0] sel);
        case (sel)
            LEN_SEL_4:  return FMT_LW'(4);
            LEN_SEL_8:  return FMT_LW'(8);
            LEN_SEL_16: return FMT_LW'(16);
            default:    return FMT_LW'(32);
        endcase
    endfunction

endpackage

// File: rtl/fmt_pkt_buf.sv
// Packet buffer: one write port filled during collection, one registered read
// port that prefetches the next word so it lines up with fmt_send_o.
module fmt_pkt_buf #(
    parameter int DW      = 32,
    parameter int MAX_LEN = 32,
    parameter int AW      = $clog2(MAX_LEN)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [MAX_LEN];
    logic [DW-1:0] rd_data_q;

    // NOTE: the storage array is deliberately left out of the reset; every word is
    // written before it is read, and a reset on it would only add a wide clear mux.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read data is forced to zero when not sending, keeping fmt_data_o quiet.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_en_i ? mem_q[rd_addr_i] : '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mcdf_formater.sv
// MCDF formatter: requests a channel from the arbiter, collects one packet into
// a local buffer, then sends it downstream as a framed start/send/end burst.
module mcdf_formater
    import mcdf_fmt_pkg::*;
#(
    parameter int DW      = 32,
    parameter int MAX_LEN = 32,
    parameter int LW      = 6
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          a2f_val_i,
    input  logic [1:0]    a2f_id_i,
    input  logic [DW-1:0] a2f_data_i,
    input  logic [2:0]    a2f_pkglen_sel_i,
    output logic          f2a_id_req_o,
    output logic          f2a_ack_o,
    input  logic          fmt_grant_i,
    output logic          fmt_req_o,
    output logic [1:0]    fmt_chid_o,
    output logic [LW-1:0] fmt_length_o,
    output logic          fmt_send_o,
    output logic [DW-1:0] fmt_data_o,
    output logic          fmt_start_o,
    output logic          fmt_end_o
);

    localparam int AW = $clog2(MAX_LEN);

    fmt_state_e    state_q, state_d;
    logic [1:0]    chid_q, chid_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] wcnt_q, wcnt_d;
    logic [LW-1:0] rcnt_q, rcnt_d;

    logic          fmt_req_q, fmt_send_q, fmt_start_q, fmt_end_q;
    logic [1:0]    fmt_chid_q;
    logic [LW-1:0] fmt_length_q;
    logic          send_next;

    assign f2a_id_req_o = (state_q == ID_REQ);
    assign f2a_ack_o    = (state_q == COLLECT) && a2f_val_i && (wcnt_q < len_q);

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        chid_d  = chid_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = '0;
        unique case (state_q)
            IDLE:   state_d = ID_REQ;
            ID_REQ: state_d = CHK;
            CHK: begin
                if (a2f_id_i == ID_NONE) begin
                    state_d = IDLE;
                end else begin
                    chid_d  = a2f_id_i;
                    len_d   = LW'(decode_len(a2f_pkglen_sel_i));
                    wcnt_d  = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (f2a_ack_o) begin
                    wcnt_d = wcnt_q + LW'(1);
                    if (wcnt_q == len_q - LW'(1)) begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (fmt_grant_i) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                // rcnt_q is the index of the word currently on fmt_data_o.
                if (rcnt_q == len_q - LW'(1)) begin
                    state_d = IDLE;
                end else begin
                    rcnt_d = rcnt_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign send_next = (state_d == SEND);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            chid_q       <= '0;
            len_q        <= '0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            fmt_req_q    <= 1'b0;
            fmt_send_q   <= 1'b0;
            fmt_start_q  <= 1'b0;
            fmt_end_q    <= 1'b0;
            fmt_chid_q   <= '0;
            fmt_length_q <= '0;
        end else begin
            state_q      <= state_d;
            chid_q       <= chid_d;
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            fmt_req_q    <= (state_d == REQ);
            fmt_send_q   <= send_next;
            fmt_start_q  <= send_next && (rcnt_d == '0);
            fmt_end_q    <= send_next && (rcnt_d == len_q - LW'(1));
            fmt_chid_q   <= (state_d == REQ || send_next) ? chid_q : '0;
            fmt_length_q <= (state_d == REQ || send_next) ? len_q : '0;
        end
    end

    fmt_pkt_buf #(
        .DW      (DW),
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .wr_en_i   (f2a_ack_o),
        .wr_addr_i (wcnt_q[AW-1:0]),
        .wr_data_i (a2f_data_i),
        .rd_en_i   (send_next),
        .rd_addr_i (rcnt_d[AW-1:0]),
        .rd_data_o (fmt_data_o)
    );

    assign fmt_req_o    = fmt_req_q;
    assign fmt_send_o   = fmt_send_q;
    assign fmt_start_o  = fmt_start_q;
    assign fmt_end_o    = fmt_end_q;
    assign fmt_chid_o   = fmt_chid_q;
    assign fmt_length_o = fmt_length_q;

endmodule

// File: tb/tb_mcdf_formater.sv
// Directed bench for mcdf_formater: a scripted arbiter/consumer drives packets,
// accepted words go to a scoreboard queue and are compared as bursts come out.
module tb_mcdf_formater;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        a2f_val_i = 1'b0;
    logic [1:0]  a2f_id_i = 2'b11;
    logic [31:0] a2f_data_i = '0;
    logic [2:0]  a2f_pkglen_sel_i = '0;
    logic        f2a_id_req_o;
    logic        f2a_ack_o;
    logic        fmt_grant_i = 1'b0;
    logic        fmt_req_o;
    logic [1:0]  fmt_chid_o;
    logic [5:0]  fmt_length_o;
    logic        fmt_send_o;
    logic [31:0] fmt_data_o;
    logic        fmt_start_o;
    logic        fmt_end_o;

    mcdf_formater #(.DW(32), .MAX_LEN(32), .LW(6)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .a2f_val_i        (a2f_val_i),
        .a2f_id_i         (a2f_id_i),
        .a2f_data_i       (a2f_data_i),
        .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
        .f2a_id_req_o     (f2a_id_req_o),
        .f2a_ack_o        (f2a_ack_o),
        .fmt_grant_i      (fmt_grant_i),
        .fmt_req_o        (fmt_req_o),
        .fmt_chid_o       (fmt_chid_o),
        .fmt_length_o     (fmt_length_o),
        .fmt_send_o       (fmt_send_o),
        .fmt_data_o       (fmt_data_o),
        .fmt_start_o      (fmt_start_o),
        .fmt_end_o        (fmt_end_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  chid;
        logic [5:0]  len;
        logic        start;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_id_req"}, 64'(f2a_id_req_o), 64'd0);
        check({tag, "_ack"},    64'(f2a_ack_o),    64'd0);
        check({tag, "_req"},    64'(fmt_req_o),    64'd0);
        check({tag, "_chid"},   64'(fmt_chid_o),   64'd0);
        check({tag, "_len"},    64'(fmt_length_o), 64'd0);
        check({tag, "_send"},   64'(fmt_send_o),   64'd0);
        check({tag, "_data"},   64'(fmt_data_o),   64'd0);
        check({tag, "_start"},  64'(fmt_start_o),  64'd0);
        check({tag, "_end"},    64'(fmt_end_o),    64'd0);
    endtask

    // Output monitor: every send cycle consumes one scoreboard entry.
    always @(negedge clk_i) begin
        if (f2a_ack_o || f2a_id_req_o)
            check("ack_idreq_excl", 64'(f2a_ack_o & f2a_id_req_o), 64'd0);
        if (fmt_send_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_send", 64'(fmt_send_o), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("send_data",   64'(fmt_data_o),   64'(mon_e.data));
                check("send_start",  64'(fmt_start_o),  64'(mon_e.start));
                check("send_end",    64'(fmt_end_o),    64'(mon_e.last));
                check("send_chid",   64'(fmt_chid_o),   64'(mon_e.chid));
                check("send_len",    64'(fmt_length_o), 64'(mon_e.len));
                check("send_req_lo", 64'(fmt_req_o),    64'd0);
            end
        end else begin
            check("quiet_frame", 64'({fmt_start_o, fmt_end_o, fmt_data_o}), 64'd0);
        end
    end

    // Arbiter model: offers words base+k until m have been accepted; n is the
    // packet length the bench expects the DUT to decode from sel.
    task automatic run_packet(input logic [1:0] id, input logic [2:0] sel, input int n,
                              input int m, input logic [31:0] base, input bit toggle);
        int   k   = 0;
        int   cyc = 0;
        bit   ph  = 1'b1;
        exp_t e;
        a2f_id_i         = id;
        a2f_pkglen_sel_i = sel;
        while (k < m && cyc < 600) begin
            @(posedge clk_i); #1;
            a2f_val_i  = toggle ? ph : 1'b1;
            ph         = ~ph;
            a2f_data_i = base + 32'(k);
            @(negedge clk_i);
            if (a2f_val_i && f2a_ack_o) begin
                if (m == n) begin
                    e.data  = base + 32'(k);
                    e.chid  = id;
                    e.len   = 6'(n);
                    e.start = (k == 0);
                    e.last  = (k == n - 1);
                    exp_q.push_back(e);
                end
                k++;
            end
            cyc++;
        end
        check("accept_count", 64'(k), 64'(m));
        if (m == n) begin
            @(posedge clk_i); #1;
            a2f_val_i  = 1'b1;
            a2f_data_i = 32'hDEAD_BEEF;
            a2f_id_i   = 2'b11;
            @(negedge clk_i);
            check("req_high",       64'(fmt_req_o),    64'd1);
            check("req_chid",       64'(fmt_chid_o),   64'(id));
            check("req_len",        64'(fmt_length_o), 64'(n));
            check("ack_after_last", 64'(f2a_ack_o),    64'd0);
            @(negedge clk_i);
            check("ack_after_last2", 64'(f2a_ack_o), 64'd0);
            @(posedge clk_i); #1;
            a2f_val_i = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(negedge clk_i); #1;
            c++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clk_i);
        check("post_send", 64'(fmt_send_o),   64'd0);
        check("post_chid", 64'(fmt_chid_o),   64'd0);
        check("post_len",  64'(fmt_length_o), 64'd0);
        check("post_req",  64'(fmt_req_o),    64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held: everything quiet. Then no channel granted: id_req every 3 cycles.
        repeat (3) @(negedge clk_i);
        check_all_zero("rst");
        a2f_val_i = 1'b1;
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk_i);
            check("retry_id_req", 64'(f2a_id_req_o), 64'(c % 3 == 2));
            check("retry_no_ack", 64'(f2a_ack_o),    64'd0);
            check("retry_no_req", 64'(fmt_req_o),    64'd0);
        end

        // Channel 1, 4 words, continuous valid, grant delayed.
        run_packet(2'd1, 3'd0, 4, 4, 32'h11, 1'b0);
        repeat (3) begin
            @(negedge clk_i);
            check("wait_req",  64'(fmt_req_o),  64'd1);
            check("wait_send", 64'(fmt_send_o), 64'd0);
        end
        @(posedge clk_i); #1;
        fmt_grant_i = 1'b1;
        @(negedge clk_i);
        check("send_before_grant", 64'(fmt_send_o), 64'd0);
        @(negedge clk_i);
        check("grant_latency", 64'(fmt_send_o),  64'd1);
        check("grant_start",   64'(fmt_start_o), 64'd1);
        wait_drain();
        fmt_grant_i = 1'b0;

        // Channel 2, sel 7 -> 32 words, valid toggling.
        run_packet(2'd2, 3'd7, 32, 32, 32'hA000_0000, 1'b1);
        @(posedge clk_i); #1;
        fmt_grant_i = 1'b1;
        wait_drain();
        fmt_grant_i = 1'b0;

        // Grant held high across two back-to-back packets.
        @(posedge clk_i); #1;
        fmt_grant_i = 1'b1;
        run_packet(2'd0, 3'd0, 4, 4, 32'hB000_0000, 1'b0);
        run_packet(2'd1, 3'd1, 8, 8, 32'hC000_0000, 1'b0);
        wait_drain();
        fmt_grant_i = 1'b0;

        // Reset after 3 of 8 words; nothing from that packet may appear.
        run_packet(2'd3 - 2'd3, 3'd1, 8, 3, 32'hD000_0000, 1'b0);
        @(posedge clk_i); #1;
        a2f_val_i = 1'b1;
        #1;
        check("pre_rst_ack", 64'(f2a_ack_o), 64'd1);
        rstn_i = 1'b0;
        #1;
        check_all_zero("midrst");
        a2f_val_i = 1'b0;
        a2f_id_i  = 2'b11;
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1;
        rstn_i      = 1'b1;
        fmt_grant_i = 1'b1;
        run_packet(2'd2, 3'd0, 4, 4, 32'hE000_0000, 1'b0);
        wait_drain();
        fmt_grant_i = 1'b0;

        repeat (2) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
